// File: rtl/glitch_sweep_sequencer_if.sv
// Host/glitcher-facing signal bundle for the glitch sweep sequencer.
// slave: the sequencer itself; master: the host/glitcher side driving it.
interface glitch_sweep_sequencer_if;
    logic        i_start;
    logic        i_abort;
    logic [31:0] i_delay_start;
    logic [31:0] i_delay_stop;
    logic [31:0] i_delay_step;
    logic [31:0] i_dur_start;
    logic [31:0] i_dur_stop;
    logic [31:0] i_dur_step;
    logic [7:0]  i_repeat;
    logic        i_glitch_done;
    logic        o_glitch_delay_DV;
    logic [31:0] o_glitch_delay;
    logic        o_glitch_duration_DV;
    logic [31:0] o_glitch_duration;
    logic        o_glitch_ctrl_DV;
    logic [7:0]  o_glitch_ctrl;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;
    logic [31:0] o_attempts;

    modport slave (
        input  i_start, i_abort, i_delay_start, i_delay_stop, i_delay_step,
               i_dur_start, i_dur_stop, i_dur_step, i_repeat, i_glitch_done,
        output o_glitch_delay_DV, o_glitch_delay, o_glitch_duration_DV,
               o_glitch_duration, o_glitch_ctrl_DV, o_glitch_ctrl,
               o_busy, o_done, o_timeout, o_attempts
    );

    modport master (
        output i_start, i_abort, i_delay_start, i_delay_stop, i_delay_step,
               i_dur_start, i_dur_stop, i_dur_step, i_repeat, i_glitch_done,
        input  o_glitch_delay_DV, o_glitch_delay, o_glitch_duration_DV,
               o_glitch_duration, o_glitch_ctrl_DV, o_glitch_ctrl,
               o_busy, o_done, o_timeout, o_attempts
    );
endinterface

// File: rtl/glitch_sweep_sequencer.sv
// Walks a (delay, duration) grid, programming and arming the glitcher
// max(repeat,1) times per point; each attempt ends on glitch_done or timeout.
module glitch_sweep_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned HOLDOFF_CYCLES = 16
) (
    input logic                     i_Clk,
    input logic                     i_Rst,
    glitch_sweep_sequencer_if.slave bus
);
    // Zero-length waits make no sense; treat them as a single cycle.
    localparam int unsigned TO_N    = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
    localparam int unsigned HO_N    = (HOLDOFF_CYCLES == 0) ? 1 : HOLDOFF_CYCLES;
    localparam logic [31:0] TO_LAST = 32'(TO_N - 1);
    localparam logic [31:0] HO_LAST = 32'(HO_N - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_DLY, S_LD_DUR, S_ARM, S_WAIT,
        S_DISARM, S_HOLD, S_FIN, S_ABORT_DIS
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;             // WAIT timeout / HOLD holdoff counter
    logic [7:0]  rep_cnt_q, rep_cnt_d;     // arms issued at current point
    logic [7:0]  rep_q, rep_d;             // effective repeat count (>=1)
    logic [31:0] dly_start_q, dly_start_d, dly_stop_q, dly_stop_d, dly_step_q, dly_step_d;
    logic [31:0] dur_stop_q, dur_stop_d, dur_step_q, dur_step_d;
    logic [31:0] delay_q, delay_d, dur_q, dur_d, attempts_q, attempts_d;
    logic        timeout_q, timeout_d;
    logic        dly_dv_q, dly_dv_d, dur_dv_q, dur_dv_d, ctrl_dv_q, ctrl_dv_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        busy_q, busy_d, done_q, done_d;

    // 33-bit next-point arithmetic so a carry out of 32 bits ends the axis.
    logic [32:0] dly_next, dur_next;
    logic        dly_exh, dur_exh;
    assign dly_next = {1'b0, delay_q} + {1'b0, dly_step_q};
    assign dur_next = {1'b0, dur_q} + {1'b0, dur_step_q};
    assign dly_exh  = dly_next[32] || (dly_next > {1'b0, dly_stop_q}) || (dly_step_q == 32'd0);
    assign dur_exh  = dur_next[32] || (dur_next > {1'b0, dur_stop_q}) || (dur_step_q == 32'd0);

    // Next-state, counters, grid walk and registered strobe values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_d       = rep_q;
        dly_start_d = dly_start_q;
        dly_stop_d  = dly_stop_q;
        dly_step_d  = dly_step_q;
        dur_stop_d  = dur_stop_q;
        dur_step_d  = dur_step_q;
        delay_d     = delay_q;
        dur_d       = dur_q;
        attempts_d  = attempts_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: if (bus.i_start) begin
                dly_start_d = bus.i_delay_start;
                dly_stop_d  = bus.i_delay_stop;
                dly_step_d  = bus.i_delay_step;
                dur_stop_d  = bus.i_dur_stop;
                dur_step_d  = bus.i_dur_step;
                rep_d       = (bus.i_repeat == 8'd0) ? 8'd1 : bus.i_repeat;
                delay_d     = bus.i_delay_start;
                dur_d       = bus.i_dur_start;
                attempts_d  = 32'd0;
                timeout_d   = 1'b0;
                state_d     = S_LD_DLY;
            end
            S_LD_DLY: begin
                rep_cnt_d = 8'd0;
                state_d   = bus.i_abort ? S_ABORT_DIS : S_LD_DUR;
            end
            S_LD_DUR: state_d = bus.i_abort ? S_ABORT_DIS : S_ARM;
            S_ARM: begin
                cnt_d   = 32'd0;
                state_d = bus.i_abort ? S_ABORT_DIS : S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_abort) begin
                    state_d = S_ABORT_DIS;
                end else if (bus.i_glitch_done) begin
                    cnt_d   = 32'd0;
                    state_d = S_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DISARM;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DISARM: begin
                cnt_d   = 32'd0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.i_abort) begin
                    state_d = S_ABORT_DIS;
                end else if (cnt_q != HO_LAST) begin
                    cnt_d = cnt_q + 32'd1;
                end else if (rep_cnt_q < rep_q) begin
                    state_d = S_ARM;
                end else if (!dly_exh) begin
                    delay_d = dly_next[31:0];
                    state_d = S_LD_DLY;
                end else if (!dur_exh) begin
                    delay_d = dly_start_q;
                    dur_d   = dur_next[31:0];
                    state_d = S_LD_DLY;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN:       state_d = S_IDLE;
            S_ABORT_DIS: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // ARM is only ever entered for one cycle, so count on entry.
        if (state_d == S_ARM) begin
            attempts_d = attempts_q + 32'd1;
            rep_cnt_d  = rep_cnt_q + 8'd1;
        end

        dly_dv_d  = (state_d == S_LD_DLY);
        dur_dv_d  = (state_d == S_LD_DUR);
        ctrl_dv_d = (state_d == S_ARM) || (state_d == S_DISARM) || (state_d == S_ABORT_DIS);
        ctrl_d    = (state_d == S_ARM) ? 8'h01 : 8'h00;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rep_cnt_q   <= '0;
            rep_q       <= '0;
            dly_start_q <= '0;
            dly_stop_q  <= '0;
            dly_step_q  <= '0;
            dur_stop_q  <= '0;
            dur_step_q  <= '0;
            delay_q     <= '0;
            dur_q       <= '0;
            attempts_q  <= '0;
            timeout_q   <= 1'b0;
            dly_dv_q    <= 1'b0;
            dur_dv_q    <= 1'b0;
            ctrl_dv_q   <= 1'b0;
            ctrl_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_q       <= rep_d;
            dly_start_q <= dly_start_d;
            dly_stop_q  <= dly_stop_d;
            dly_step_q  <= dly_step_d;
            dur_stop_q  <= dur_stop_d;
            dur_step_q  <= dur_step_d;
            delay_q     <= delay_d;
            dur_q       <= dur_d;
            attempts_q  <= attempts_d;
            timeout_q   <= timeout_d;
            dly_dv_q    <= dly_dv_d;
            dur_dv_q    <= dur_dv_d;
            ctrl_dv_q   <= ctrl_dv_d;
            ctrl_q      <= ctrl_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.o_glitch_delay_DV    = dly_dv_q;
    assign bus.o_glitch_delay       = delay_q;
    assign bus.o_glitch_duration_DV = dur_dv_q;
    assign bus.o_glitch_duration    = dur_q;
    assign bus.o_glitch_ctrl_DV     = ctrl_dv_q;
    assign bus.o_glitch_ctrl        = ctrl_q;
    assign bus.o_busy               = busy_q;
    assign bus.o_done               = done_q;
    assign bus.o_timeout            = timeout_q;
    assign bus.o_attempts           = attempts_q;
endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Bench for glitch_sweep_sequencer: scenario tasks against a grid model.
module tb_glitch_sweep_sequencer;
    localparam int TO = 16;
    localparam int HO = 4;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    glitch_sweep_sequencer_if bus();

    glitch_sweep_sequencer #(.TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .bus(bus)
    );

    initial forever #5 i_Clk = ~i_Clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    logic resp_done = 1'b0, man_done = 1'b0;
    int   resp_dly = 0;
    assign bus.i_glitch_done = resp_done | man_done;

    // Observed traffic
    logic [63:0] arm_q[$];       // {duration, delay} at each arm
    int          arm_cyc_q[$];
    int          dis_cyc_q[$];
    logic [31:0] dly_dv_q[$];
    int          done_cnt = 0;
    logic [63:0] exp_q[$];

    // Captured right after the start edge
    int s_cyc;
    logic busy_e1, timeout_e1, dly_dv_e1;
    logic [31:0] dly_e1;

    // Monitor: sample on falling edge, away from the active edge.
    always @(negedge i_Clk) begin
        if (!i_Rst) begin
            if (bus.o_glitch_delay_DV) dly_dv_q.push_back(bus.o_glitch_delay);
            if (bus.o_glitch_ctrl_DV) begin
                if (bus.o_glitch_ctrl == 8'h01) begin
                    arm_q.push_back({bus.o_glitch_duration, bus.o_glitch_delay});
                    arm_cyc_q.push_back(cyc);
                end else begin
                    dis_cyc_q.push_back(cyc);
                end
            end
            if (bus.o_done) done_cnt = done_cnt + 1;
            if (bus.o_glitch_delay_DV || bus.o_glitch_duration_DV || bus.o_glitch_ctrl_DV) begin
                checks = checks + 1;
                if ((int'(bus.o_glitch_delay_DV) + int'(bus.o_glitch_duration_DV) + int'(bus.o_glitch_ctrl_DV)) != 1) begin
                    errors = errors + 1;
                    $display("FAIL dv_exclusive at cyc %0d: dly=%b dur=%b ctrl=%b, want exactly one",
                             cyc, bus.o_glitch_delay_DV, bus.o_glitch_duration_DV, bus.o_glitch_ctrl_DV);
                end
            end
        end
    end

    // Glitcher stand-in: pulse done resp_dly cycles after each arm (0 = never).
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge i_Clk);
            resp_done = 1'b0;
            if (i_Rst) cd = 0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) resp_done = 1'b1;
            end
            if (!i_Rst && bus.o_glitch_ctrl_DV && bus.o_glitch_ctrl == 8'h01 && resp_dly > 0) cd = resp_dly;
        end
    end

    // Reference: enumerate the grid from the axis rules, each point max(rep,1) times.
    function automatic void build_model(input logic [31:0] ds, de, dst, us, ue, ust, input logic [7:0] rep);
        logic [31:0] dl[$], ul[$];
        longint unsigned v;
        int r;
        exp_q.delete();
        v = ds;
        while (1) begin
            dl.push_back(v[31:0]);
            if (dst == 0) break;
            v = v + dst;
            if (v > 64'hFFFF_FFFF || v > de) break;
        end
        v = us;
        while (1) begin
            ul.push_back(v[31:0]);
            if (ust == 0) break;
            v = v + ust;
            if (v > 64'hFFFF_FFFF || v > ue) break;
        end
        r = (rep == 0) ? 1 : int'(rep);
        foreach (ul[j]) foreach (dl[i]) for (int k = 0; k < r; k++) exp_q.push_back({ul[j], dl[i]});
    endfunction

    function automatic int arm_diff();
        int n, m;
        m = (arm_q.size() < exp_q.size()) ? arm_q.size() : exp_q.size();
        n = (arm_q.size() > exp_q.size()) ? arm_q.size() - exp_q.size() : exp_q.size() - arm_q.size();
        for (int i = 0; i < m; i++) if (arm_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic kick(input logic [31:0] ds, de, dst, us, ue, ust, input logic [7:0] rep);
        @(negedge i_Clk);
        arm_q.delete(); arm_cyc_q.delete(); dis_cyc_q.delete(); dly_dv_q.delete();
        done_cnt = 0;
        bus.i_delay_start = ds; bus.i_delay_stop = de; bus.i_delay_step = dst;
        bus.i_dur_start = us;   bus.i_dur_stop = ue;   bus.i_dur_step = ust;
        bus.i_repeat = rep;
        bus.i_start = 1'b1;
        s_cyc = cyc;
        @(negedge i_Clk);
        bus.i_start = 1'b0;
        // Scramble ranges: the latched copies must be what is used.
        bus.i_delay_start = $urandom; bus.i_delay_stop = $urandom; bus.i_delay_step = $urandom;
        bus.i_dur_stop = $urandom; bus.i_dur_step = $urandom; bus.i_repeat = 8'($urandom);
        busy_e1 = bus.o_busy; timeout_e1 = bus.o_timeout;
        dly_dv_e1 = bus.o_glitch_delay_DV; dly_e1 = bus.o_glitch_delay;
    endtask

    task automatic wait_idle(output bit ok);
        for (int i = 0; i < 20000; i++) begin
            if (!bus.o_busy) break;
            @(negedge i_Clk);
        end
        ok = !bus.o_busy;
        repeat (2) @(negedge i_Clk);
    endtask

    task automatic wait_arm(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_Clk);
            if (bus.o_glitch_ctrl_DV && bus.o_glitch_ctrl == 8'h01) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [111:0] outs;
        i_Rst = 1'b1;
        repeat (3) @(negedge i_Clk);
        outs = {bus.o_glitch_delay_DV, bus.o_glitch_delay, bus.o_glitch_duration_DV, bus.o_glitch_duration,
                bus.o_glitch_ctrl_DV, bus.o_glitch_ctrl, bus.o_busy, bus.o_done, bus.o_timeout, bus.o_attempts};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
        i_Rst = 1'b0;
        @(negedge i_Clk);
    endtask

    task automatic test_linear();
        bit ok;
        resp_dly = 3;
        kick(32'h10, 32'h12, 1, 7, 7, 1, 1);
        wait_idle(ok);
        build_model(32'h10, 32'h12, 1, 7, 7, 1, 1);
        checks++; if (!ok) begin errors++; $display("FAIL linear_end busy stuck, want idle"); end
        checks++; if (busy_e1 !== 1'b1 || dly_dv_e1 !== 1'b1) begin errors++; $display("FAIL linear_e1 busy=%b dly_dv=%b want 1 1", busy_e1, dly_dv_e1); end
        checks++; if (arm_cyc_q.size() == 0 || arm_cyc_q[0] - s_cyc != 3) begin errors++; $display("FAIL linear_arm_latency got %0d want 3", arm_cyc_q.size() ? arm_cyc_q[0] - s_cyc : -1); end
        checks++; if (arm_diff() != 0) begin errors++; $display("FAIL linear_arms diffs %0d got %0d arms want %0d", arm_diff(), arm_q.size(), exp_q.size()); end
        checks++; if (dly_dv_q.size() != 3 || dly_dv_q[0] !== 32'h10 || dly_dv_q[1] !== 32'h11 || dly_dv_q[2] !== 32'h12) begin
            errors++; $display("FAIL linear_delay_dv got %0d writes first %h want 10,11,12", dly_dv_q.size(), dly_dv_q.size() ? dly_dv_q[0] : 32'hx); end
        checks++; if (bus.o_attempts !== 32'd3) begin errors++; $display("FAIL linear_attempts got %0d want 3", bus.o_attempts); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL linear_done got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_2d_repeat();
        bit ok;
        resp_dly = 3;
        kick(0, 4, 2, 1, 2, 1, 2);
        wait_idle(ok);
        build_model(0, 4, 2, 1, 2, 1, 2);
        checks++; if (!ok) begin errors++; $display("FAIL grid_end busy stuck, want idle"); end
        checks++; if (arm_diff() != 0) begin errors++; $display("FAIL grid_arms diffs %0d got %0d arms want %0d", arm_diff(), arm_q.size(), exp_q.size()); end
        checks++; if (bus.o_attempts !== 32'd12) begin errors++; $display("FAIL grid_attempts got %0d want 12", bus.o_attempts); end
        // repeat: WAIT(3) + HOLD(HO) ; new point additionally LD_DLY + LD_DUR
        checks++; if (arm_cyc_q.size() < 3 || arm_cyc_q[1] - arm_cyc_q[0] != 3 + 1 + HO || arm_cyc_q[2] - arm_cyc_q[1] != 3 + 1 + HO + 2) begin
            errors++; $display("FAIL grid_spacing got %0d/%0d want %0d/%0d", arm_cyc_q.size() > 1 ? arm_cyc_q[1] - arm_cyc_q[0] : -1,
                                arm_cyc_q.size() > 2 ? arm_cyc_q[2] - arm_cyc_q[1] : -1, 3 + 1 + HO, 3 + 1 + HO + 2); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL grid_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_timeout();
        bit ok;
        resp_dly = 0;
        kick(3, 3, 1, 9, 9, 1, 2);
        wait_idle(ok);
        build_model(3, 3, 1, 9, 9, 1, 2);
        checks++; if (!ok) begin errors++; $display("FAIL to_end busy stuck, want idle"); end
        checks++; if (arm_diff() != 0) begin errors++; $display("FAIL to_arms got %0d want %0d", arm_q.size(), exp_q.size()); end
        checks++; if (dis_cyc_q.size() != 2) begin errors++; $display("FAIL to_disarms got %0d want 2", dis_cyc_q.size()); end
        checks++; if (dis_cyc_q.size() == 0 || arm_cyc_q.size() == 0 || dis_cyc_q[0] - arm_cyc_q[0] != TO + 1) begin
            errors++; $display("FAIL to_latency got %0d want %0d", (dis_cyc_q.size() && arm_cyc_q.size()) ? dis_cyc_q[0] - arm_cyc_q[0] : -1, TO + 1); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL to_done got %0d want 1", done_cnt); end
        repeat (5) @(negedge i_Clk);
        checks++; if (bus.o_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", bus.o_timeout); end
        resp_dly = 2;
        kick(1, 1, 1, 1, 1, 1, 1);
        checks++; if (timeout_e1 !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", timeout_e1); end
        wait_idle(ok);
        checks++; if (bus.o_timeout !== 1'b0 || !ok) begin errors++; $display("FAIL to_after got %b ok=%0d want 0 1", bus.o_timeout, ok); end
    endtask

    task automatic test_boundary();
        bit ok;
        logic [31:0] p[4][7];
        p[0] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1};
        p[1] = '{7, 100, 0, 3, 50, 0, 1};
        p[2] = '{5, 3, 1, 5, 3, 1, 1};
        p[3] = '{1, 1, 1, 2, 2, 1, 0};
        resp_dly = 1;
        for (int t = 0; t < 4; t++) begin
            kick(p[t][0], p[t][1], p[t][2], p[t][3], p[t][4], p[t][5], p[t][6][7:0]);
            wait_idle(ok);
            build_model(p[t][0], p[t][1], p[t][2], p[t][3], p[t][4], p[t][5], p[t][6][7:0]);
            checks++;
            if (!ok || arm_diff() != 0 || arm_q.size() != 1 || bus.o_attempts !== 32'd1 || arm_q[0] !== {p[t][3], p[t][0]}) begin
                errors++; $display("FAIL boundary_%0d ok=%0d arms=%0d attempts=%0d want single arm at %h/%h", t, ok, arm_q.size(), bus.o_attempts, p[t][0], p[t][3]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] ds, de, dst, us, ue, ust;
        logic [7:0] rep;
        for (int n = 0; n < 6; n++) begin
            ds  = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
            de  = ds + $urandom_range(0, 6);
            dst = $urandom_range(0, 3);
            us  = $urandom;
            ue  = us + $urandom_range(0, 4);
            ust = $urandom_range(0, 3);
            rep = 8'($urandom_range(0, 3));
            resp_dly = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 5));
            kick(ds, de, dst, us, ue, ust, rep);
            wait_idle(ok);
            build_model(ds, de, dst, us, ue, ust, rep);
            checks++;
            if (!ok || arm_diff() != 0 || bus.o_attempts !== 32'(exp_q.size()) || done_cnt != 1) begin
                errors++; $display("FAIL random_%0d ok=%0d arms=%0d attempts=%0d done=%0d want arms %0d done 1", n, ok, arm_q.size(), bus.o_attempts, done_cnt, exp_q.size());
            end
            checks++;
            if (dis_cyc_q.size() != ((resp_dly == 0) ? exp_q.size() : 0) || bus.o_timeout !== (resp_dly == 0)) begin
                errors++; $display("FAIL random_to_%0d disarms=%0d timeout=%b resp=%0d", n, dis_cyc_q.size(), bus.o_timeout, resp_dly);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        resp_dly = 0;
        kick(0, 10, 1, 0, 0, 1, 3);
        wait_arm(ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_arm not seen"); end
        @(negedge i_Clk);
        bus.i_abort = 1'b1; man_done = 1'b1;
        @(negedge i_Clk);
        bus.i_abort = 1'b0; man_done = 1'b0;
        checks++; if (bus.o_glitch_ctrl_DV !== 1'b1 || bus.o_glitch_ctrl !== 8'h00) begin
            errors++; $display("FAIL abort_disarm got dv=%b ctrl=%h want 1 00", bus.o_glitch_ctrl_DV, bus.o_glitch_ctrl); end
        @(negedge i_Clk);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.o_busy); end
        repeat (HO + 4) @(negedge i_Clk);
        checks++; if (done_cnt != 0 || bus.o_attempts !== 32'd1 || arm_q.size() != 1) begin
            errors++; $display("FAIL abort_after done=%0d attempts=%0d arms=%0d want 0 1 1", done_cnt, bus.o_attempts, arm_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [111:0] outs;
        resp_dly = 0;
        kick(32'h20, 32'h30, 1, 4, 4, 1, 1);
        wait_arm(ok);
        @(negedge i_Clk);
        man_done = 1'b1;
        @(negedge i_Clk);
        man_done = 1'b0;
        i_Rst = 1'b1;
        @(negedge i_Clk);
        outs = {bus.o_glitch_delay_DV, bus.o_glitch_delay, bus.o_glitch_duration_DV, bus.o_glitch_duration,
                bus.o_glitch_ctrl_DV, bus.o_glitch_ctrl, bus.o_busy, bus.o_done, bus.o_timeout, bus.o_attempts};
        checks++; if (!ok || outs !== '0) begin errors++; $display("FAIL rst_mid got %h ok=%0d want 0", outs, ok); end
        i_Rst = 1'b0;
        resp_dly = 2;
        kick(32'h20, 32'h21, 1, 4, 4, 1, 1);
        checks++; if (dly_dv_e1 !== 1'b1 || dly_e1 !== 32'h20) begin errors++; $display("FAIL rst_restart got dv=%b dly=%h want 1 20", dly_dv_e1, dly_e1); end
        wait_idle(ok);
        build_model(32'h20, 32'h21, 1, 4, 4, 1, 1);
        checks++; if (!ok || arm_diff() != 0) begin errors++; $display("FAIL rst_sweep arms=%0d want %0d ok=%0d", arm_q.size(), exp_q.size(), ok); end
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_repeat = '0;
        bus.i_delay_start = '0; bus.i_delay_stop = '0; bus.i_delay_step = '0;
        bus.i_dur_start = '0; bus.i_dur_stop = '0; bus.i_dur_step = '0;
        test_reset();
        test_linear();
        test_2d_repeat();
        test_timeout();
        test_boundary();
        test_random();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
